// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and the
// default sizing constants. PE-array instances take their defaults from here
// so that every column agrees on length and latency.
package mac_seq_ctrl_pkg;

    localparam int DEF_BIT_WIDTH    = 8;
    localparam int DEF_MAX_LEN      = 16;
    localparam int DEF_LEN_W        = 5;
    localparam int DEF_PROD_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_seq_acc.sv
// Accumulator for the MAC sequencer: internal running sum plus the published
// result register. Optional saturation is selected by the MAC_SEQ_SAT_EN macro;
// without it the sum wraps modulo 2^ACC_WIDTH.
module mac_seq_acc
    import mac_seq_ctrl_pkg::*;
#(
    parameter int PROD_W    = 2 * DEF_BIT_WIDTH,
    parameter int ACC_WIDTH = 2 * DEF_BIT_WIDTH + DEF_LEN_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_add_en,
    input  logic                 i_publish,
    input  logic [PROD_W-1:0]    i_product,
    output logic [ACC_WIDTH-1:0] o_acc
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign prod_ext = ACC_WIDTH'(i_product);

`ifdef MAC_SEQ_SAT_EN
    logic ovf_q;
    logic ovf_nxt;

    // Returns {carry, clipped sum}; the sum is pinned at all-ones on carry.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[ACC_WIDTH]) begin
            return {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return sum;
    endfunction

    // Next accumulator value; once overflow is seen the sum stays pinned.
    always_comb begin
        logic [ACC_WIDTH:0] res;
        acc_nxt = acc_q;
        ovf_nxt = ovf_q;
        res     = '0;
        if (i_clear) begin
            acc_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (i_add_en) begin
            res     = sat_add(acc_q, prod_ext);
            ovf_nxt = ovf_q | res[ACC_WIDTH];
            acc_nxt = ovf_nxt ? {ACC_WIDTH{1'b1}} : res[ACC_WIDTH-1:0];
        end
    end

    // Sticky overflow flag, cleared at the start of each dot product.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_nxt;
        end
    end
`else
    // Plain modular add; the carry out is simply dropped.
    function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
        return a + b;
    endfunction

    // Next accumulator value.
    always_comb begin
        acc_nxt = acc_q;
        if (i_clear) begin
            acc_nxt = '0;
        end else if (i_add_en) begin
            acc_nxt = wrap_add(acc_q, prod_ext);
        end
    end
`endif

    // Running sum plus the published copy; publishing takes the next value so
    // the final product lands in o_acc in the same edge that enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            o_acc <= '0;
        end else begin
            acc_q <= acc_nxt;
            if (i_publish) begin
                o_acc <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: accepts weight/feature pairs, issues them one at a time to a
// fixed-latency multiplier, accumulates the products and pulses o_done with
// the final sum. Build option: define MAC_SEQ_SAT_EN for a saturating sum.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int PROD_LATENCY = DEF_PROD_LATENCY,
    parameter int ACC_WIDTH    = 2 * BIT_WIDTH + LEN_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [LEN_W-1:0]       i_len,
    input  logic                   i_pair_valid,
    input  logic [BIT_WIDTH-1:0]   i_pix_weight,
    input  logic [BIT_WIDTH-1:0]   i_pix_feature,
    output logic                   o_pair_ready,
    output logic                   o_mul_en,
    output logic [BIT_WIDTH-1:0]   o_mul_weight,
    output logic [BIT_WIDTH-1:0]   o_mul_feature,
    output logic                   o_mul_core_en,
    input  logic [2*BIT_WIDTH-1:0] i_mul_product,
    output logic [ACC_WIDTH-1:0]   o_acc,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int LAT_W  = (PROD_LATENCY > 1) ? $clog2(PROD_LATENCY) : 1;

    mac_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             acc_clear;
    logic             acc_add;
    logic             acc_publish;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

    // State, length and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Next state, multiplier handshake and accumulator controls.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        acc_clear     = 1'b0;
        acc_add       = 1'b0;
        acc_publish   = 1'b0;
        o_pair_ready  = 1'b0;
        o_mul_en      = 1'b0;
        o_mul_weight  = '0;
        o_mul_feature = '0;
        o_mul_core_en = 1'b0;
        o_done        = 1'b0;
        o_busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_d     = '0;
                    lat_d     = '0;
                    acc_clear = 1'b1;
                    if (i_len == '0) begin
                        // Empty dot product: publish zero straight away.
                        acc_publish = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        len_d   = clamp_len(i_len);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                o_pair_ready  = 1'b1;
                o_mul_core_en = 1'b1;
                o_busy        = 1'b1;
                if (i_pair_valid) begin
                    o_mul_en      = 1'b1;
                    o_mul_weight  = i_pix_weight;
                    o_mul_feature = i_pix_feature;
                    cnt_d         = cnt_q + 1'b1;
                    lat_d         = LAT_W'(PROD_LATENCY - 1);
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_mul_core_en = 1'b1;
                o_busy        = 1'b1;
                if (lat_q == '0) begin
                    // Product of the last issue is at the multiplier output now.
                    acc_add = 1'b1;
                    if (cnt_q == len_q) begin
                        acc_publish = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mac_seq_acc #(
        .PROD_W    (PROD_W),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (acc_clear),
        .i_add_en  (acc_add),
        .i_publish (acc_publish),
        .i_product (i_mul_product),
        .o_acc     (o_acc)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (default accumulator width and a
// 16-bit accumulator) share one stimulus stream, each with its own 3-cycle
// multiplier model; results are compared to a dot product computed directly
// from the pairs sent.
module tb_mac_seq_ctrl;

    localparam int BW    = 8;
    localparam int ACC_A = 2 * BW + 5;
    localparam int ACC_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start;
    logic [4:0]       len;
    logic             pvalid;
    logic [BW-1:0]    pw_in, pf_in;

    logic             a_ready, a_mul_en, a_core_en, a_done, a_busy;
    logic [BW-1:0]    a_w, a_f;
    logic [2*BW-1:0]  a_prod;
    logic [ACC_A-1:0] a_acc;

    logic             b_ready, b_mul_en, b_core_en, b_done, b_busy;
    logic [BW-1:0]    b_w, b_f;
    logic [2*BW-1:0]  b_prod;
    logic [ACC_B-1:0] b_acc;

    mac_seq_ctrl dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
        .i_pair_valid(pvalid), .i_pix_weight(pw_in), .i_pix_feature(pf_in),
        .o_pair_ready(a_ready), .o_mul_en(a_mul_en), .o_mul_weight(a_w),
        .o_mul_feature(a_f), .o_mul_core_en(a_core_en), .i_mul_product(a_prod),
        .o_acc(a_acc), .o_done(a_done), .o_busy(a_busy)
    );

    mac_seq_ctrl #(.ACC_WIDTH(ACC_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
        .i_pair_valid(pvalid), .i_pix_weight(pw_in), .i_pix_feature(pf_in),
        .o_pair_ready(b_ready), .o_mul_en(b_mul_en), .o_mul_weight(b_w),
        .o_mul_feature(b_f), .o_mul_core_en(b_core_en), .i_mul_product(b_prod),
        .o_acc(b_acc), .o_done(b_done), .o_busy(b_busy)
    );

    // Multiplier models: three register stages, input stage zeroed when idle.
    logic [2*BW-1:0] pa [3];
    logic [2*BW-1:0] pb [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pa[i] <= '0;
                pb[i] <= '0;
            end
        end else begin
            pa[0] <= (a_core_en && a_mul_en) ? 16'(a_w) * 16'(a_f) : 16'd0;
            pb[0] <= (b_core_en && b_mul_en) ? 16'(b_w) * 16'(b_f) : 16'd0;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pb[1] <= pb[0];
            pb[2] <= pb[1];
        end
    end
    assign a_prod = pa[2];
    assign b_prod = pb[2];

    // Cycle counter and event monitor sampled mid-cycle.
    int cyc = 0;
    int done_cnt = 0;
    int issue_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (a_mul_en) issue_q.push_back(cyc);
        if (a_done) done_cnt <= done_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;
    int qw[$];
    int qf[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference dot product over the queued pairs, reduced to a given width.
    function automatic logic [63:0] model_acc(input int width);
        longint s = 0;
        longint lim = (64'sd1 <<< width);
        foreach (qw[i]) s += longint'(qw[i]) * longint'(qf[i]);
`ifdef MAC_SEQ_SAT_EN
        if (s > lim - 1) return 64'(lim - 1);
        return 64'(s);
`else
        return 64'(s % lim);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dot(input int l);
        start = 1'b1;
        len   = 5'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input int w, input int f, input int gap, output int ready_seen);
        bit acc;
        ready_seen = 0;
        pvalid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (a_ready) ready_seen++;
            tick();
        end
        pvalid = 1'b1;
        pw_in  = 8'(w);
        pf_in  = 8'(f);
        acc    = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = a_ready;
            tick();
            if (acc) break;
        end
        pvalid = 1'b0;
        if (!acc) check("pair_accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input bit poke);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (a_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", ok, 1);
        check("busy_in_done", a_busy, 0);
        check("b_done_aligned", b_done, 1);
        if (poke) begin
            start = 1'b1;
            len   = 5'd7;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic run_dot(input int l, input int max_gap, input bit busy_poke,
                           input bit done_poke, input string tag);
        int rs;
        int d0;
        int n;
        issue_q.delete();
        d0 = done_cnt;
        n  = qw.size();
        start_dot(l);
        for (int i = 0; i < n; i++) begin
            send_pair(qw[i], qf[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, rs);
            if (busy_poke && i == 0) begin
                start = 1'b1;
                len   = 5'd9;
                tick();
                start = 1'b0;
            end
        end
        wait_done(done_poke);
        check({tag, "_acc_a"}, a_acc, model_acc(ACC_A));
        check({tag, "_acc_b"}, b_acc, model_acc(ACC_B));
        check({tag, "_issues"}, issue_q.size(), n);
        for (int i = 1; i < issue_q.size(); i++) begin
            check({tag, "_pacing"}, (issue_q[i] - issue_q[i-1]) >= 4, 1);
        end
        tick();
        tick();
        tick();
        check({tag, "_one_done"}, done_cnt - d0, 1);
        check({tag, "_idle_after"}, a_busy, 0);
        check({tag, "_acc_held"}, a_acc, model_acc(ACC_A));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rs;
        int l;
        int n;
        // Reset with busy-looking inputs: everything must stay at reset values.
        rst_n = 1'b0; start = 1'b1; len = 5'd3; pvalid = 1'b1; pw_in = 8'd5; pf_in = 8'd7;
        tick(); tick(); tick();
        check("rst_acc", a_acc, 0);
        check("rst_done", a_done, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 0);
        check("rst_mul_en", a_mul_en, 0);
        check("rst_core_en", a_core_en, 0);
        check("rst_mul_w", a_w, 0);
        check("rst_mul_f", a_f, 0);
        start = 1'b0; pvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Basic length-4 dot product with back-to-back pairs.
        qw = '{1, 3, 5, 7};
        qf = '{2, 4, 6, 8};
        run_dot(4, 0, 0, 0, "len4");
        check("len4_acc_100", a_acc, 100);
        for (int i = 1; i < issue_q.size(); i++) begin
            check("len4_gap_exact", issue_q[i] - issue_q[i-1], 4);
        end

        // Zero length: done in the very next cycle with a zero result.
        issue_q.delete();
        start_dot(0);
        check("len0_done_next", a_done, 1);
        check("len0_acc", a_acc, 0);
        check("len0_ready", a_ready, 0);
        tick();
        check("len0_done_once", a_done, 0);
        check("len0_no_issue", issue_q.size(), 0);

        // Stall in ISSUE for five cycles before the third pair.
        qw = '{2, 4, 10};
        qf = '{3, 5, 10};
        issue_q.delete();
        start_dot(3);
        send_pair(2, 3, 0, rs);
        send_pair(4, 5, 0, rs);
        send_pair(10, 10, 8, rs);
        check("stall_ready_cycles", rs, 5);
        wait_done(0);
        check("stall_acc", a_acc, 126);
        check("stall_acc_model", a_acc, model_acc(ACC_A));
        tick();

        // Start pulses while busy and in the DONE cycle are ignored.
        qw = '{$urandom_range(0, 255), $urandom_range(0, 255)};
        qf = '{$urandom_range(0, 255), $urandom_range(0, 255)};
        run_dot(2, 0, 1, 1, "ignore_start");

        // Reset during WAIT of pair 2 abandons the operation.
        start_dot(3);
        send_pair(9, 9, 0, rs);
        send_pair(8, 8, 0, rs);
        check("mid_busy_before_rst", a_busy, 1);
        n = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_core_en", a_core_en, 0);
        check("mid_rst_acc", a_acc, 0);
        check("mid_rst_done", a_done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        check("mid_rst_no_done", done_cnt - n, 0);
        qw = '{255};
        qf = '{255};
        run_dot(1, 0, 0, 0, "after_rst");
        check("after_rst_65025", a_acc, 65025);

        // Overflow of the 16-bit accumulator instance.
        qw = '{255, 255};
        qf = '{255, 255};
        run_dot(2, 0, 0, 0, "ovf");
`ifdef MAC_SEQ_SAT_EN
        check("ovf_b_sat", b_acc, 65535);
`else
        check("ovf_b_wrap", b_acc, 64514);
`endif
        check("ovf_a_full", a_acc, 130050);

        // Randomized lengths and gaps, including clamped over-length requests.
        for (int r = 0; r < 8; r++) begin
            l = (r == 6) ? 31 : (r == 7) ? 17 : int'($urandom_range(1, 16));
            n = (l > 16) ? 16 : l;
            qw.delete();
            qf.delete();
            for (int i = 0; i < n; i++) begin
                qw.push_back(int'($urandom_range(0, 255)));
                qf.push_back(int'($urandom_range(0, 255)));
            end
            run_dot(l, 2, 0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
